// File: rtl/ulpi_send.sv
// ULPI transmit path: TXCMD, payload bytes from a show-ahead buffer, then STP.
// Defining ULPI_SEND_TIMEOUT_EN aborts a CMD phase that never sees NXT.
module ulpi_send #(
  parameter int LEN_W   = 10,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_ULPI,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       PID,
  input  logic [LEN_W-1:0] LEN,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             underrun,
  input  logic [7:0]       TX_DATA,
  input  logic             TX_empty,
  output logic             DATA_re,
  input  logic             DIR,
  input  logic             NXT,
  output logic [7:0]       DATA_O,
  output logic             STP
);

  typedef enum logic [2:0] {IDLE, CMD, DATA, STOP, ERR} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] counter, counter_next;
  logic [7:0]       data_next;
  logic             stp_next, done_next, aborted_next, underrun_next;

`ifdef ULPI_SEND_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt, wait_next;
`endif

  assign busy = (state != IDLE);

  // CMD and DATA share one handshake: the byte on DATA_O is accepted when NXT=1 and DIR=0
  always_comb begin
    state_next    = state;
    counter_next  = counter;
    data_next     = DATA_O;
    stp_next      = STP;
    done_next     = 1'b0;
    aborted_next  = 1'b0;
    underrun_next = 1'b0;
    DATA_re       = 1'b0;
`ifdef ULPI_SEND_TIMEOUT_EN
    wait_next     = wait_cnt;
`endif
    unique case (state)
      IDLE: begin
        data_next = 8'h00;
        stp_next  = 1'b0;
        if (start && !DIR) begin
          counter_next = LEN;
          data_next    = 8'h40 | {4'h0, PID};
          state_next   = CMD;
`ifdef ULPI_SEND_TIMEOUT_EN
          wait_next    = 8'h00;
`endif
        end
      end
      CMD, DATA: begin
        if (DIR) begin
          data_next    = 8'h00;
          stp_next     = 1'b0;
          aborted_next = 1'b1;
          state_next   = IDLE;
        end else if (NXT) begin
          if (counter == '0) begin
            data_next  = 8'h00;
            stp_next   = 1'b1;
            state_next = STOP;
          end else if (!TX_empty) begin
            DATA_re      = 1'b1;
            data_next    = TX_DATA;
            counter_next = counter - 1'b1;
            state_next   = DATA;
          end else begin
            data_next  = 8'hFF;
            stp_next   = 1'b1;
            state_next = ERR;
          end
        end
`ifdef ULPI_SEND_TIMEOUT_EN
        else if (state == CMD) begin
          if (wait_cnt == WAIT_LAST) begin
            data_next    = 8'h00;
            stp_next     = 1'b0;
            aborted_next = 1'b1;
            state_next   = IDLE;
          end else begin
            wait_next = wait_cnt + 8'h01;
          end
        end
`endif
      end
      STOP: begin
        data_next  = 8'h00;
        stp_next   = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        data_next     = 8'h00;
        stp_next      = 1'b0;
        underrun_next = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The ULPI bus is launched on the falling edge so the PHY sees stable data at its rising edge
  always_ff @(negedge clk_ULPI) begin
    if (!rst) begin
      state    <= IDLE;
      counter  <= '0;
      DATA_O   <= 8'h00;
      STP      <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_next;
      counter  <= counter_next;
      DATA_O   <= data_next;
      STP      <= stp_next;
      done     <= done_next;
      aborted  <= aborted_next;
      underrun <= underrun_next;
    end
  end

`ifdef ULPI_SEND_TIMEOUT_EN
  always_ff @(negedge clk_ULPI) begin
    if (!rst) wait_cnt <= 8'h00;
    else      wait_cnt <= wait_next;
  end
`endif

endmodule

// File: doc/ulpi_send.md
Name: ulpi_send

Overview:
- ULPI transmit path, LINK->PHY. Takes a PID and payload bytes from a show-ahead byte buffer and emits one USB packet on the ULPI bus: TXCMD, payload, then STP.
- Sits beside the ULPI receive path on the same ULPI pins and shares clk_ULPI.
- A higher-level controller starts packets and observes done/aborted/underrun.

Parameters:
- LEN_W, 10, width of the payload length input and of the internal remaining-byte counter.
- TIMEOUT, 255, clk_ULPI cycles to wait for NXT in CMD (used only with ULPI_SEND_TIMEOUT_EN).

Ports:
- clk_ULPI  in  1  60MHz ULPI clock; all registers update on its falling edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  request a packet; sampled only in IDLE.
- PID  in  4  USB PID nibble.
- LEN  in  LEN_W  payload byte count; 0 = PID-only packet.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: packet completed.
- aborted  out  1  one-cycle pulse: PHY took the bus (DIR) or timeout.
- underrun  out  1  one-cycle pulse: buffer empty mid-payload.
- TX_DATA  in  8  head byte of the byte buffer (show-ahead).
- TX_empty  in  1  byte buffer empty.
- DATA_re  out  1  pop the byte buffer; combinational.
- DIR  in  1  ULPI DIR.
- NXT  in  1  ULPI NXT.
- DATA_O  out  8  ULPI data LINK->PHY; registered.
- STP  out  1  ULPI STP; registered.

Behaviour:
- Reset values (while rst=0 at a falling edge): state=IDLE, DATA_O=0, STP=0, busy=0, done=0, aborted=0, underrun=0, counter=0. Reset mid-packet returns to IDLE immediately; no STP is issued.
- States: IDLE, CMD, DATA, STOP, ERR.
- IDLE:
  - DATA_O=0, STP=0.
  - If start=1 and DIR=0: latch PID and LEN, counter<=LEN, DATA_O<=8'h40|{4'h0,PID}, go to CMD.
  - If start=1 and DIR=1: the request is ignored; no pulse.
- CMD: hold TXCMD on DATA_O until NXT=1 and DIR=0.
  - If LEN=0: go to STOP.
  - If LEN>0 and TX_empty=0: DATA_O<=TX_DATA, DATA_re=1 that cycle, counter<=counter-1, go to DATA.
  - If LEN>0 and TX_empty=1: go to ERR.
- DATA: hold DATA_O until NXT=1 and DIR=0.
  - If counter=0: go to STOP.
  - Else if TX_empty=0: DATA_O<=TX_DATA, DATA_re=1, counter<=counter-1, stay in DATA.
  - Else: go to ERR.
- STOP: one cycle, DATA_O=8'h00, STP=1. Next state IDLE; done pulses in the cycle after STOP (IDLE entry).
- ERR: one cycle, DATA_O=8'hFF, STP=1 (forced transmit error). Next state IDLE with an underrun pulse.
- DIR=1 in CMD or DATA:
  - Next edge: DATA_O<=0, STP<=0, go to IDLE, aborted pulse.
  - Bytes already popped are not restored; counter discarded.
- DIR is ignored in STOP and ERR; those cycles always complete.
- DATA_re is never asserted outside the CMD->DATA and DATA->DATA transfers above. Exactly LEN pops per completed packet.
- NXT with DIR=1 is never treated as a byte accept.
- Back-to-back: start may be asserted in the cycle done pulses; it is accepted (state is IDLE).
- counter is unsigned LEN_W bits; LEN up to 2^LEN_W-1 is supported with no wrap.

Optional Feature:
- Macro ULPI_SEND_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on CMD entry, incremented on each CMD cycle without NXT.
  - On reaching TIMEOUT: DATA_O<=0, STP<=0, go to IDLE, aborted pulse; no bytes popped.
- Undefined: CMD waits for NXT indefinitely; the counter logic is absent.

Test Plan:
- PID=4'h2 (ACK), LEN=0, NXT after 2 cycles -> DATA_O=8'h42 held until NXT, then STP=1 with DATA_O=0 for 1 cycle, done pulse, DATA_re never high.
- PID=4'h3 (DATA0), LEN=3, buffer {A1,B2,C3}, NXT continuous -> DATA_O sequence 43,A1,B2,C3,00(STP); 3 DATA_re pulses; done once.
- Same as above but NXT deasserted for 2 cycles while DATA_O=B2 -> B2 held 3 cycles; no extra DATA_re; final sequence unchanged.
- LEN=4, buffer holds 2 bytes -> after second byte accepted: DATA_O=FF with STP=1 for 1 cycle, underrun pulse, 2 DATA_re total.
- DIR rises in DATA after 1 byte -> next edge DATA_O=0, STP=0, aborted pulse, busy=0; rst=0 mid-DATA -> all outputs 0 next edge.
- With ULPI_SEND_TIMEOUT_EN, TIMEOUT=255, NXT never asserted -> aborted at cycle 255 of CMD; without the macro, busy stays 1.
